dly_buf_reader: RTL and testbench

//  Read-side counterpart of the fixed SRL delay line: a circular sample buffer written on every CE,

---
 rtl/dly_buf_reader.sv | 227 ++++++++++++++++++++++
 tb/tb_dly_buf_reader.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dly_buf_reader.sv
// dly_buf_reader: circular sample buffer written on every CE. A trigger reads out a window of
//   WIN+1 words that starts LAT samples behind the write point.
// Latency: with samples available, TRIG sampled at edge k gives DV after edge k+3. The peak rate is
//   one word per 3 clocks.
// Backpressure: each word holds DOUT/DV/LAST until DV&RDY. Writes never stall. On overrun the oldest
//   unread sample is dropped and OVR is flagged.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_ce, i_din       sample enable / sample data (written at wr_ptr, wr_ptr++)
//   i_lat, i_win      trigger latency (samples) and window length-1, captured at accepted trigger
//   i_trig            readout request, accepted only when idle
//   i_rdy             downstream ready
//   o_dout, o_dv      window word and its valid
//   o_last            final word of the window (qualified by o_dv)
//   o_busy            readout in progress
//   o_missed          one-cycle pulse: trigger arrived while busy and was dropped
//   o_ovr             sticky: unread data overwritten during the current readout
module dly_buf_reader #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 8,
  parameter int WIN_BITS  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ce,
  input  logic [WIDTH-1:0]     i_din,
  input  logic [ADDR_BITS-1:0] i_lat,
  input  logic [WIN_BITS-1:0]  i_win,
  input  logic                 i_trig,
  input  logic                 i_rdy,
  output logic [WIDTH-1:0]     o_dout,
  output logic                 o_dv,
  output logic                 o_last,
  output logic                 o_busy,
  output logic                 o_missed,
  output logic                 o_ovr
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] A_ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] A_MAX = '1;
  localparam logic [WIN_BITS-1:0]  W_ONE = WIN_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Sample storage: one write port, one registered read port
  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [WIDTH-1:0]     r_q;

  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS-1:0] r_lag;       // written-but-unread samples at/after rd_ptr
  logic [ADDR_BITS-1:0] r_lat;
  logic [WIN_BITS-1:0]  r_win_cnt;   // words still to send after the current one

  logic [WIDTH-1:0]     r_dout;
  logic                 r_dv;
  logic                 r_last;
  logic                 r_missed;
  logic                 r_ovr;

  logic                 w_accept;
  logic                 w_rd_issue;
  logic                 w_xfer;
  logic                 w_ovr_set;
  logic [ADDR_BITS-1:0] w_load_ptr;
  logic [ADDR_BITS-1:0] w_rd_ptr_nxt;
  logic [ADDR_BITS-1:0] w_lag_nxt;

  // ---------------------------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rd_issue  = 1'b0;
    w_xfer      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_trig) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_READ;
      end
      S_READ: begin
        // With LAT=0, or when the reader has caught up, wait here for the next sample.
        if (r_lag != '0) begin
          w_rd_issue  = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        w_xfer = r_dv & i_rdy;
        if (w_xfer) begin
          w_state_nxt = (r_win_cnt == '0) ? S_IDLE : S_READ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Read pointer / lag bookkeeping
  // lag counts samples the reader still owns. When a CE would push it past depth-1, the writer
  // is about to clobber the oldest owned sample. That sample is given up (rd_ptr++) and the event
  // is flagged, so the window still completes with the right word count.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    w_load_ptr   = r_wr_ptr - r_lat;
    w_rd_ptr_nxt = r_rd_ptr;
    w_lag_nxt    = r_lag;
    w_ovr_set    = 1'b0;
    if (r_state == S_LOAD) begin
      w_rd_ptr_nxt = w_load_ptr;
      w_lag_nxt    = r_lat;
      if (i_ce) begin
        if (r_lat == A_MAX) begin
          w_rd_ptr_nxt = w_load_ptr + A_ONE;
          w_ovr_set    = 1'b1;
        end else begin
          w_lag_nxt = r_lat + A_ONE;
        end
      end
    end else if (r_state != S_IDLE) begin
      if (w_rd_issue) begin
        // A read and a write on the same edge cancel in lag.
        w_rd_ptr_nxt = r_rd_ptr + A_ONE;
        if (!i_ce) begin
          w_lag_nxt = r_lag - A_ONE;
        end
      end else if (i_ce) begin
        if (r_lag == A_MAX) begin
          w_rd_ptr_nxt = r_rd_ptr + A_ONE;
          w_ovr_set    = 1'b1;
        end else begin
          w_lag_nxt = r_lag + A_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_lag     <= '0;
      r_lat     <= '0;
      r_win_cnt <= '0;
      r_dout    <= '0;
      r_dv      <= 1'b0;
      r_last    <= 1'b0;
      r_missed  <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_lag    <= w_lag_nxt;
      r_missed <= i_trig && (r_state != S_IDLE);

      // The write side runs regardless of readout state.
      if (i_ce) begin
        r_wr_ptr <= r_wr_ptr + A_ONE;
      end

      if (w_accept) begin
        r_lat     <= i_lat;
        r_win_cnt <= i_win;
        r_ovr     <= 1'b0;
      end else if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end

      if (r_state == S_WAIT) begin
        r_dout <= r_q;
        r_dv   <= 1'b1;
        r_last <= (r_win_cnt == '0);
      end else if (w_xfer) begin
        r_dv   <= 1'b0;
        r_last <= 1'b0;
        if (r_win_cnt != '0) begin
          r_win_cnt <= r_win_cnt - W_ONE;
        end
      end
    end
  end

  // Storage is never cleared. A read of the address being written on the same edge returns the
  // old contents.
  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      r_mem[r_wr_ptr] <= i_din;
    end
    if (w_rd_issue) begin
      r_q <= r_mem[r_rd_ptr];
    end
  end

  assign o_dout   = r_dout;
  assign o_dv     = r_dv;
  assign o_last   = r_last;
  assign o_busy   = (r_state != S_IDLE);
  assign o_missed = r_missed;
  assign o_ovr    = r_ovr;

endmodule

// File: tb/tb_dly_buf_reader.sv
module tb_dly_buf_reader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [15:0] din;
  logic [7:0]  lat;
  logic [3:0]  win;
  logic        trig;
  logic        rdy;
  logic [15:0] dout;
  logic        dv;
  logic        last;
  logic        busy;
  logic        missed;
  logic        ovr;

  always #5 clk = ~clk;

  dly_buf_reader #(
    .WIDTH    (16),
    .ADDR_BITS(8),
    .WIN_BITS (4)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_ce    (ce),
    .i_din   (din),
    .i_lat   (lat),
    .i_win   (win),
    .i_trig  (trig),
    .i_rdy   (rdy),
    .o_dout  (dout),
    .o_dv    (dv),
    .o_last  (last),
    .o_busy  (busy),
    .o_missed(missed),
    .o_ovr   (ovr)
  );

  // Reference model: every written sample is kept by its global write index. A window is the
  // run of indices starting LAT samples back from the write count at the cycle after acceptance.
  typedef struct {
    int idx;
    bit is_last;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] hist [0:65535];
  int          wcount = 0;
  bit          m_busy = 0;
  bit          m_load = 0;
  bit          m_ovr = 0;
  bit          exp_missed = 0;
  bit          xfer_last = 0;
  bit          was_busy;
  int          m_lat = 0;
  int          m_win = 0;
  int          start;

  int total = 0;
  int bad = 0;
  int n_xfer = 0;
  int n_missed = 0;
  bit chk_en = 0;
  int hidx;

  int ce_mode = 0;     // 0 manual, 1 every clk, 2 random, 4 every 4th clk
  int rdy_mode = 0;    // 0 manual, 1 always, 2 random
  bit din_rand = 0;
  int din_cnt = 0;
  int phase = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_chk(input string name, input int n, input int limit);
    total++;
    if (n >= limit) begin
      bad++;
      $display("FAIL %s: waited %0d cycles, limit %0d", name, n, limit);
    end
  endtask

  // Model update on the active edge.
  always @(posedge clk) begin
    if (rst) begin
      m_busy     = 0;
      m_load     = 0;
      m_ovr      = 0;
      exp_missed = 0;
      xfer_last  = 0;
      wcount     = 0;
      sb.delete();
    end else begin
      was_busy   = m_busy;
      exp_missed = trig && was_busy;
      if (m_load) begin
        start = wcount - m_lat;
        // Window reaching back the full buffer plus a new write: oldest sample is lost.
        if (m_lat == DEPTH - 1 && ce) begin
          start++;
          m_ovr = 1;
        end
        for (int i = 0; i <= m_win; i++) begin
          sb.push_back('{idx: start + i, is_last: (i == m_win)});
        end
        m_load = 0;
      end
      if (xfer_last) begin
        m_busy    = 0;
        xfer_last = 0;
      end
      if (trig && !was_busy) begin
        m_busy = 1;
        m_load = 1;
        m_lat  = int'(lat);
        m_win  = int'(win);
        m_ovr  = 0;
      end
      if (ce) begin
        hist[wcount[15:0]] = din;
        wcount++;
      end
    end
  end

  // Monitor: compares outputs mid-cycle against the model and the scoreboard head.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("missed", int'(missed), int'(exp_missed));
      chk("ovr", int'(ovr), int'(m_ovr));
      if (missed) n_missed++;
      if (dv) begin
        if (sb.size() == 0) begin
          chk("dv_unexpected", int'(dv), 0);
        end else begin
          hidx = sb[0].idx;
          chk("dout", int'(dout), int'(hist[hidx[15:0]]));
          chk("last", int'(last), int'(sb[0].is_last));
          if (rdy) begin
            n_xfer++;
            if (sb[0].is_last) xfer_last = 1;
            sb.delete(0);
          end
        end
      end
    end
  end

  // Background sample / ready driver, a little after the edge so test-sequence settings win.
  initial forever begin
    @(posedge clk);
    #2;
    case (ce_mode)
      1: ce = 1'b1;
      2: ce = ($urandom_range(0, 1) == 1);
      4: begin
        ce    = (phase == 0);
        phase = (phase + 1) % 4;
      end
      default: ;
    endcase
    if (ce_mode != 0 && ce) begin
      din = din_rand ? 16'($urandom) : 16'(din_cnt);
      din_cnt++;
    end
    if (rdy_mode == 1) rdy = 1'b1;
    else if (rdy_mode == 2) rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; trigger is sampled on the next edge, returns #1 after it.
  task automatic fire(input int l, input int w);
    lat  = 8'(l);
    win  = 4'(w);
    trig = 1'b1;
    @(posedge clk);
    #1;
    trig = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((m_busy || m_load || sb.size() != 0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    bound_chk("idle_timeout", n, limit);
    chk("busy_after_window", int'(busy), 0);
  endtask

  task automatic wait_dv(input int limit);
    int n;
    n = 0;
    while (!dv && n < limit) begin
      @(negedge clk);
      n++;
    end
    bound_chk("dv_timeout", n, limit);
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat_seen;
    int n0;
    int m0;
    int l;
    int w;

    rst  = 1'b1;
    ce   = 1'b0;
    din  = '0;
    trig = 1'b0;
    rdy  = 1'b0;
    lat  = '0;
    win  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dv", int'(dv), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_missed", int'(missed), 0);
    chk("rst_ovr", int'(ovr), 0);
    chk_en = 1;
    @(posedge clk);
    #1;

    // Counting stream, one sample per clock; window LAT=10, WIN=3 with RDY high.
    din_cnt  = 0;
    din_rand = 0;
    ce_mode  = 1;
    rdy_mode = 1;
    n = 0;
    while (wcount < 100 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    bound_chk("fill_timeout", n, 500);
    n0 = n_xfer;
    fire(10, 3);
    lat_seen = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dv) begin
        lat_seen = c;
        break;
      end
    end
    chk("trig_to_dv_latency", lat_seen, 3);
    @(posedge clk);
    #1;
    wait_idle(200);
    chk("t1_words", n_xfer - n0, 4);

    // Same window with the second word stalled for 20 clocks.
    rdy_mode = 0;
    rdy = 1'b1;
    n0 = n_xfer;
    fire(10, 3);
    n = 0;
    while (n_xfer == n0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bound_chk("first_word_timeout", n, 50);
    @(posedge clk);
    #1;
    rdy = 1'b0;
    wait_dv(50);
    for (int i = 0; i < 20; i++) begin
      chk("stall_dv", int'(dv), 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rdy = 1'b1;
    wait_idle(200);
    chk("t3_words", n_xfer - n0, 4);

    // A second trigger while busy is dropped with a single MISSED pulse.
    rdy_mode = 1;
    m0 = n_missed;
    n0 = n_xfer;
    fire(10, 3);
    cyc(1);
    fire(20, 5);
    wait_idle(200);
    chk("missed_pulses", n_missed - m0, 1);
    chk("t4_words", n_xfer - n0, 4);

    // LAT=0: window is the next samples to arrive; CE only every 4th clock.
    ce_mode = 4;
    n0 = n_xfer;
    fire(0, 1);
    wait_idle(300);
    chk("t2_words", n_xfer - n0, 2);

    // Randomised windows, data, CE and RDY, with dropped triggers mixed in.
    din_rand = 1;
    ce_mode  = 2;
    rdy_mode = 2;
    for (int t = 0; t < 30; t++) begin
      l = $urandom_range(0, (wcount < 60) ? wcount : 60);
      w = $urandom_range(0, 15);
      fire(l, w);
      n = 0;
      while ((m_busy || m_load || sb.size() != 0) && n < 2000) begin
        trig = m_busy && ($urandom_range(0, 15) == 0);
        @(posedge clk);
        #1;
        n++;
      end
      trig = 1'b0;
      bound_chk("rand_window_timeout", n, 2000);
    end

    // Overrun: the window reaches back the whole 256-deep buffer while CE runs every clock.
    din_rand = 0;
    ce_mode  = 1;
    rdy_mode = 0;
    rdy = 1'b0;
    fire(DEPTH - 1, 0);
    cyc(3);
    chk("ovr_set", int'(ovr), 1);
    cyc(10);
    rdy = 1'b1;
    wait_idle(200);
    chk("ovr_sticky_idle", int'(ovr), 1);
    rdy_mode = 1;
    fire(5, 0);
    chk("ovr_clear_on_trig", int'(ovr), 0);
    wait_idle(200);

    // Reset during HOLD aborts the readout.
    rdy_mode = 0;
    rdy = 1'b0;
    fire(DEPTH - 1, 0);
    wait_dv(50);
    @(posedge clk);
    #1;
    chk("pre_rst_ovr", int'(ovr), 1);
    ce_mode = 0;
    ce  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_dv", int'(dv), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ovr", int'(ovr), 0);
    chk("midrst_last", int'(last), 0);
    chk("midrst_dout", int'(dout), 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      ce  = 1'b1;
      din = 16'(i);
    end
    @(posedge clk);
    #1;
    ce = 1'b0;
    rdy_mode = 1;
    fire(5, 0);
    wait_dv(50);
    chk("post_rst_dout", int'(dout), 15);
    @(posedge clk);
    #1;
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
